// File: rtl/mx_xfer_sequencer_if.sv
// rtl/mx_xfer_sequencer_if.sv - command channel and mxregs load/read bus for mx_xfer_sequencer
//
// Purpose: bundles the transfer-command handshake, the mxregs write port and the
//          status pulses into one interface.
// Modports:
//   master - the sequencer: takes cmd_* and reg_line; drives cmd_ready, load_addr,
//            load_en, data_line, busy, done and cmd_err
//   slave  - the environment, meaning the command source together with mxregs
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 MOV, 01 LDI, 10 CLR, 11 SWAP
//   cmd_dst              destination load address (mxregs encoding)
//   cmd_src              source register index
//   cmd_imm              immediate word for LDI
//   reg_line             flattened register contents read back from mxregs
//   load_addr/load_en    mxregs write address and write enable
//   data_line            write word broadcast to every lane
//   busy/done/cmd_err    status outputs

interface mx_xfer_sequencer_if #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 16
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [7:0]                   cmd_dst;
    logic [3:0]                   cmd_src;
    logic [WORD_LENGTH-1:0]       cmd_imm;
    logic [DEPTH*WORD_LENGTH-1:0] reg_line;
    logic [7:0]                   load_addr;
    logic                         load_en;
    logic [DEPTH*WORD_LENGTH-1:0] data_line;
    logic                         busy;
    logic                         done;
    logic                         cmd_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, reg_line,
        output cmd_ready, load_addr, load_en, data_line, busy, done, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, reg_line,
        input  cmd_ready, load_addr, load_en, data_line, busy, done, cmd_err
    );
endinterface

// File: rtl/mx_xfer_sequencer.sv
// rtl/mx_xfer_sequencer.sv - in-order register-transfer sequencer in front of mxregs
//
// Purpose: accepts one MOV/LDI/CLR/SWAP command at a time and performs it through
//          the mxregs load port. Source operands are read from reg_line. Because
//          commands run strictly one after another, a source read can never
//          overtake an earlier write.
// Ports:
//   clk   in   clock; every state update happens on the rising edge
//   rst   in   asynchronous reset, active low
//   bus   mx_xfer_sequencer_if.master; carries the command handshake, the mxregs
//         load port, reg_line, and the busy/done/cmd_err pulses

module mx_xfer_sequencer #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mx_xfer_sequencer_if.master    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_SWAP2 = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    logic [1:0]             state;
    logic [1:0]             op_q;
    logic [7:0]             dst_q;
    logic [3:0]             src_q;
    logic [WORD_LENGTH-1:0] imm_q;
    logic [WORD_LENGTH-1:0] tmp;

    // The last address and word driven are held, so the bus stays quiet between writes.
    logic [7:0]             addr_hold;
    logic [WORD_LENGTH-1:0] word_hold;

    logic [WORD_LENGTH-1:0] src_word;
    logic [WORD_LENGTH-1:0] dst_word;
    logic [WORD_LENGTH-1:0] exec_word;
    logic [WORD_LENGTH-1:0] out_word;
    logic                   cmd_illegal;
    logic                   dst_out_of_map;
    logic                   dst_not_reg;
    logic                   src_not_reg;
    logic                   accept;

    assign accept = bus.cmd_valid && (state == ST_IDLE);

    // Addresses 0x10/0x11 are composite loads, so they are legal for writes but do not
    // name a single register. SWAP must read its destination back, and it therefore
    // needs a plain index.
    assign dst_out_of_map = bus.cmd_dst > 8'h11;
    assign dst_not_reg    = 32'(bus.cmd_dst) >= DEPTH;
    assign src_not_reg    = 32'(bus.cmd_src) >= DEPTH;
    assign cmd_illegal    = dst_out_of_map
                         || ((bus.cmd_op == OP_SWAP) && dst_not_reg)
                         || (((bus.cmd_op == OP_MOV) || (bus.cmd_op == OP_SWAP)) && src_not_reg);

    // The source and destination words are selected with a mux, not with a variable
    // part-select, so an index wider than needed never reaches the select logic.
    always_comb begin
        src_word = '0;
        dst_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (src_q == 4'(i)) src_word = bus.reg_line[i*WORD_LENGTH +: WORD_LENGTH];
            if (dst_q == 8'(i)) dst_word = bus.reg_line[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    // MOV and SWAP sample reg_line live in the EXEC cycle.
    always_comb begin
        exec_word = '0;
        case (op_q)
            OP_MOV:  exec_word = src_word;
            OP_LDI:  exec_word = imm_q;
            OP_CLR:  exec_word = '0;
            OP_SWAP: exec_word = src_word;
            default: exec_word = '0;
        endcase
    end

    always_comb begin
        out_word      = word_hold;
        bus.load_addr = addr_hold;
        bus.load_en   = 1'b0;
        if (state == ST_EXEC) begin
            out_word      = exec_word;
            bus.load_addr = dst_q;
            bus.load_en   = 1'b1;
        end else if (state == ST_SWAP2) begin
            out_word      = tmp;
            bus.load_addr = {4'h0, src_q};
            bus.load_en   = 1'b1;
        end
    end

    assign bus.data_line = {DEPTH{out_word}};
    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = ((state == ST_EXEC) && (op_q != OP_SWAP)) || (state == ST_SWAP2);
    assign bus.cmd_err   = (state == ST_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= 2'b00;
            dst_q     <= 8'h00;
            src_q     <= 4'h0;
            imm_q     <= '0;
            tmp       <= '0;
            addr_hold <= 8'h00;
            word_hold <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.cmd_op;
                        dst_q <= bus.cmd_dst;
                        src_q <= bus.cmd_src;
                        imm_q <= bus.cmd_imm;
                        state <= cmd_illegal ? ST_ERR : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    addr_hold <= dst_q;
                    word_hold <= exec_word;
                    if (op_q == OP_SWAP) begin
                        // The destination is captured on the same edge that overwrites it.
                        tmp   <= dst_word;
                        state <= ST_SWAP2;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SWAP2: begin
                    addr_hold <= {4'h0, src_q};
                    word_hold <= tmp;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mx_xfer_sequencer.sv
// tb/tb_mx_xfer_sequencer.sv - directed self-checking bench for mx_xfer_sequencer with a small mxregs model

module tb_mx_xfer_sequencer;

    localparam int WL    = 8;
    localparam int DEP   = 8;
    localparam int R_A   = 0;
    localparam int R_X   = 1;
    localparam int R_Y   = 2;
    localparam int R_D   = 3;
    localparam int R_FLG = DEP - 1;

    localparam logic [1:0] MOV  = 2'b00;
    localparam logic [1:0] LDI  = 2'b01;
    localparam logic [1:0] CLR  = 2'b10;
    localparam logic [1:0] SWAP = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [WL-1:0] mregs [DEP];

    mx_xfer_sequencer_if #(.WORD_LENGTH(WL), .DEPTH(DEP)) bus ();

    mx_xfer_sequencer #(.WORD_LENGTH(WL), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mxregs model: not reset with the sequencer, composite loads hit FLAGS as well
    initial for (int i = 0; i < DEP; i++) mregs[i] = '0;

    always @(posedge clk) begin
        if (bus.load_en) begin
            if (bus.load_addr < 8'(DEP)) mregs[bus.load_addr[2:0]] <= bus.data_line[WL-1:0];
            else if (bus.load_addr == 8'h10) begin
                mregs[R_FLG] <= bus.data_line[WL-1:0];
                mregs[R_A]   <= bus.data_line[WL-1:0];
            end else if (bus.load_addr == 8'h11) begin
                mregs[R_FLG] <= bus.data_line[WL-1:0];
                mregs[R_D]   <= bus.data_line[WL-1:0];
            end
        end
    end

    always_comb begin
        bus.reg_line = '0;
        for (int i = 0; i < DEP; i++) bus.reg_line[i*WL +: WL] = mregs[i];
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns #1 after the accept edge, which is the cycle after
    // acceptance. The count of cycles spent waiting for cmd_ready is returned in waited.
    task automatic send(input logic [1:0] op, input logic [7:0] dst, input logic [3:0] src,
                        input logic [7:0] imm, output int waited);
        waited        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
        bus.cmd_imm   = imm;
        while (!bus.cmd_ready && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (!bus.cmd_ready) begin
            failures++;
            $display("FAIL send_ready_timeout got=%0b exp=1", bus.cmd_ready);
        end
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = $urandom_range(0, 3);
        bus.cmd_dst   = 8'($urandom);
        bus.cmd_src   = 4'($urandom);
        bus.cmd_imm   = 8'($urandom);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%0b exp=1", bus.cmd_ready); end
        checks++; if (bus.load_en !== 1'b0) begin failures++; $display("FAIL rst_load_en got=%0b exp=0", bus.load_en); end
        checks++; if (bus.load_addr !== 8'h00) begin failures++; $display("FAIL rst_load_addr got=%0h exp=0", bus.load_addr); end
        checks++; if (bus.data_line !== '0) begin failures++; $display("FAIL rst_data_line got=%0h exp=0", bus.data_line); end
        checks++; if ({bus.busy, bus.done, bus.cmd_err} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {bus.busy, bus.done, bus.cmd_err}); end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_ldi();
        int w;
        send(LDI, 8'h00, 4'h0, 8'h5A, w);
        checks++; if (bus.load_en !== 1'b1) begin failures++; $display("FAIL ldi_load_en got=%0b exp=1", bus.load_en); end
        checks++; if (bus.load_addr !== 8'h00) begin failures++; $display("FAIL ldi_load_addr got=%0h exp=0", bus.load_addr); end
        checks++; if (bus.data_line !== {DEP{8'h5A}}) begin failures++; $display("FAIL ldi_data_line got=%0h exp=%0h", bus.data_line, {DEP{8'h5A}}); end
        checks++; if ({bus.done, bus.busy, bus.cmd_ready} !== 3'b110) begin failures++; $display("FAIL ldi_exec_status got=%b exp=110", {bus.done, bus.busy, bus.cmd_ready}); end
        step();
        checks++; if ({bus.load_en, bus.done, bus.busy} !== 3'b000) begin failures++; $display("FAIL ldi_after_status got=%b exp=000", {bus.load_en, bus.done, bus.busy}); end
        checks++; if (mregs[R_A] !== 8'h5A) begin failures++; $display("FAIL ldi_a_value got=%0h exp=5a", mregs[R_A]); end
        checks++; if (bus.data_line !== {DEP{8'h5A}}) begin failures++; $display("FAIL ldi_data_hold got=%0h exp=%0h", bus.data_line, {DEP{8'h5A}}); end
    endtask

    task automatic test_back_to_back();
        int w;
        send(LDI, 8'(R_X), 4'h0, 8'h11, w);
        send(MOV, 8'(R_Y), 4'(R_X), 8'h00, w);
        checks++; if (w !== 1) begin failures++; $display("FAIL b2b_ready_gap got=%0d exp=1", w); end
        checks++; if (bus.load_addr !== 8'h02 || bus.data_line[WL-1:0] !== 8'h11) begin failures++; $display("FAIL b2b_mov_write got=%0h/%0h exp=2/11", bus.load_addr, bus.data_line[WL-1:0]); end
        step();
        checks++; if (mregs[R_Y] !== 8'h11) begin failures++; $display("FAIL b2b_y_value got=%0h exp=11", mregs[R_Y]); end
    endtask

    task automatic test_swap();
        int w;
        send(LDI, 8'(R_Y), 4'h0, 8'h22, w);
        send(LDI, 8'(R_D), 4'h0, 8'h33, w);
        send(SWAP, 8'(R_Y), 4'(R_D), 8'h00, w);
        checks++; if ({bus.busy, bus.done, bus.load_en} !== 3'b101) begin failures++; $display("FAIL swap_exec_status got=%b exp=101", {bus.busy, bus.done, bus.load_en}); end
        checks++; if (bus.load_addr !== 8'h02 || bus.data_line[WL-1:0] !== 8'h33) begin failures++; $display("FAIL swap_exec_write got=%0h/%0h exp=2/33", bus.load_addr, bus.data_line[WL-1:0]); end
        step();
        checks++; if ({bus.busy, bus.done, bus.load_en} !== 3'b111) begin failures++; $display("FAIL swap2_status got=%b exp=111", {bus.busy, bus.done, bus.load_en}); end
        checks++; if (bus.load_addr !== 8'h03 || bus.data_line !== {DEP{8'h22}}) begin failures++; $display("FAIL swap2_write got=%0h/%0h exp=3/22", bus.load_addr, bus.data_line[WL-1:0]); end
        step();
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL swap_idle_status got=%b exp=00", {bus.busy, bus.done}); end
        checks++; if (mregs[R_Y] !== 8'h33 || mregs[R_D] !== 8'h22) begin failures++; $display("FAIL swap_values got=Y%0h/D%0h exp=Y33/D22", mregs[R_Y], mregs[R_D]); end
    endtask

    task automatic test_illegal();
        int w;
        logic [WL-1:0] snap [DEP];
        logic [1:0]  ops  [3];
        logic [7:0]  dsts [3];
        logic [3:0]  srcs [3];
        ops[0] = LDI;  dsts[0] = 8'h12; srcs[0] = 4'h0;
        ops[1] = MOV;  dsts[1] = 8'h00; srcs[1] = 4'(DEP);
        ops[2] = SWAP; dsts[2] = 8'(DEP); srcs[2] = 4'h0;
        for (int i = 0; i < DEP; i++) snap[i] = mregs[i];
        for (int k = 0; k < 3; k++) begin
            send(ops[k], dsts[k], srcs[k], 8'h77, w);
            checks++; if ({bus.load_en, bus.cmd_err, bus.done, bus.busy} !== 4'b0101) begin failures++; $display("FAIL illegal%0d_err_cycle got=%b exp=0101", k, {bus.load_en, bus.cmd_err, bus.done, bus.busy}); end
            step();
            checks++; if ({bus.load_en, bus.cmd_err, bus.cmd_ready} !== 3'b001) begin failures++; $display("FAIL illegal%0d_after got=%b exp=001", k, {bus.load_en, bus.cmd_err, bus.cmd_ready}); end
        end
        for (int i = 0; i < DEP; i++) begin
            checks++; if (mregs[i] !== snap[i]) begin failures++; $display("FAIL illegal_reg%0d got=%0h exp=%0h", i, mregs[i], snap[i]); end
        end
    endtask

    task automatic test_composite();
        int w;
        send(LDI, 8'h10, 4'h0, 8'hFF, w);
        checks++; if (bus.load_addr !== 8'h10) begin failures++; $display("FAIL comp_addr10 got=%0h exp=10", bus.load_addr); end
        step();
        checks++; if (mregs[R_FLG] !== 8'hFF || mregs[R_A] !== 8'hFF) begin failures++; $display("FAIL comp_ldi got=F%0h/A%0h exp=Fff/Aff", mregs[R_FLG], mregs[R_A]); end
        send(CLR, 8'h11, 4'h0, 8'hAB, w);
        checks++; if (bus.load_addr !== 8'h11 || bus.data_line !== '0) begin failures++; $display("FAIL comp_clr_write got=%0h/%0h exp=11/0", bus.load_addr, bus.data_line); end
        step();
        checks++; if (mregs[R_FLG] !== 8'h00 || mregs[R_D] !== 8'h00 || mregs[R_A] !== 8'hFF) begin failures++; $display("FAIL comp_clr got=F%0h/D%0h/A%0h exp=F0/D0/Aff", mregs[R_FLG], mregs[R_D], mregs[R_A]); end
    endtask

    task automatic test_self_swap();
        int w;
        send(SWAP, 8'(R_X), 4'(R_X), 8'h00, w);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL self_exec_done got=%0b exp=0", bus.done); end
        step();
        checks++; if (bus.done !== 1'b1 || bus.data_line[WL-1:0] !== 8'h11) begin failures++; $display("FAIL self_swap2 got=%0b/%0h exp=1/11", bus.done, bus.data_line[WL-1:0]); end
        step();
        checks++; if (mregs[R_X] !== 8'h11) begin failures++; $display("FAIL self_x_value got=%0h exp=11", mregs[R_X]); end
    endtask

    task automatic test_reset_mid();
        int w;
        send(SWAP, 8'(R_Y), 4'(R_X), 8'h00, w);
        step();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mid_in_swap2 got=%0b exp=1", bus.done); end
        rst = 1'b0;
        #1;
        checks++; if ({bus.cmd_ready, bus.load_en, bus.busy, bus.done, bus.cmd_err} !== 5'b10000) begin failures++; $display("FAIL mid_async_status got=%b exp=10000", {bus.cmd_ready, bus.load_en, bus.busy, bus.done, bus.cmd_err}); end
        checks++; if (bus.load_addr !== 8'h00 || bus.data_line !== '0) begin failures++; $display("FAIL mid_async_bus got=%0h/%0h exp=0/0", bus.load_addr, bus.data_line); end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL mid_release got=%0b%0b exp=10", bus.cmd_ready, bus.done); end
        checks++; if (mregs[R_X] !== 8'h11 || mregs[R_Y] !== 8'h11) begin failures++; $display("FAIL mid_values got=X%0h/Y%0h exp=X11/Y11", mregs[R_X], mregs[R_Y]); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_dst   = 8'h00;
        bus.cmd_src   = 4'h0;
        bus.cmd_imm   = 8'h00;
        test_reset();
        test_ldi();
        test_back_to_back();
        test_swap();
        test_illegal();
        test_composite();
        test_self_swap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
